// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op select width, op encodings and result-flag bundle for the bitwise logic unit.
package logic_unit_pkg;
   localparam int OP_W = 3;
   localparam logic [OP_W-1:0] OP_AND   = 3'd0;
   localparam logic [OP_W-1:0] OP_OR    = 3'd1;
   localparam logic [OP_W-1:0] OP_XOR   = 3'd2;
   localparam logic [OP_W-1:0] OP_NAND  = 3'd3;
   localparam logic [OP_W-1:0] OP_NOR   = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR  = 3'd5;
   localparam logic [OP_W-1:0] OP_NOTA  = 3'd6;
   localparam logic [OP_W-1:0] OP_PASSA = 3'd7;
   typedef struct packed {
      logic any;
      logic zero;
      logic parity;
   } flags_t;
endpackage

// File: rtl/bitwise_op.sv
// bitwise_op: combinational WIDTH-bit bitwise function; ports op (select), a, b (operands), y (result).
module bitwise_op
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);
   always_comb begin
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_XOR:  y = a ^ b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XNOR: y = ~(a ^ b);
         OP_NOTA: y = ~a;
         default: y = a;
      endcase
   end
endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise unit with accumulator and registered result flags.
// Ports: clock/reset_n (async active-low); in_valid/in_ready/in_op/in_a/in_b/in_first input beat;
// out_valid/out_ready/out_data/out_any/out_zero/out_parity registered result.
module logic_unit_pipe
   import logic_unit_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_any,
   output logic             out_zero,
   output logic             out_parity
);
   logic [WIDTH-1:0] r_r1;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_out_data;
   logic             r_v1;
   logic             r_out_valid;
   flags_t           r_flags;
   logic [WIDTH-1:0] w_a_eff;
   logic [WIDTH-1:0] w_y;
   logic             w_s2_adv;
   logic             w_s1_adv;
   logic             w_accept;

   assign w_s2_adv = ~r_out_valid | out_ready;
   assign w_s1_adv = ~r_v1 | w_s2_adv;
   assign w_accept = in_valid & w_s1_adv;
   assign w_a_eff  = in_first ? in_a : r_acc;
   assign in_ready = w_s1_adv;

   // Single function instance feeds both the stage-1 register and the accumulator.
   bitwise_op #(.WIDTH(WIDTH)) u_op (
      .op(in_op),
      .a (w_a_eff),
      .b (in_b),
      .y (w_y)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_v1  <= 1'b0;
         r_r1  <= '0;
         r_acc <= '0;
      end else begin
         if (w_s1_adv) r_v1 <= in_valid;
         if (w_accept) begin
            r_r1  <= w_y;
            r_acc <= w_y;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_flags     <= '{any: 1'b0, zero: 1'b1, parity: 1'b0};
      end else if (w_s2_adv) begin
         r_out_valid <= r_v1;
         r_out_data  <= r_r1;
         r_flags     <= '{any: |r_r1, zero: ~|r_r1, parity: ^r_r1};
      end
   end

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_any    = r_flags.any;
   assign out_zero   = r_flags.zero;
   assign out_parity = r_flags.parity;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed vector bench for logic_unit_pipe at WIDTH 16 and WIDTH 8.
module tb_logic_unit_pipe;
   typedef struct {
      logic [2:0]  op;
      logic        first;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] d;
      logic        any;
      logic        zero;
      logic        par;
   } vec_t;

   localparam int N = 13;

   logic        clk = 1'b0;
   logic        rst_n, iv, ir, first, ov, ordy, oany, ozero, opar;
   logic [2:0]  op;
   logic [15:0] a, b, od;
   logic        rst8_n, iv8, ir8, first8, ov8, ordy8, oany8, ozero8, opar8;
   logic [2:0]  op8;
   logic [7:0]  a8, b8, od8;
   int          checks = 0;
   int          errors = 0;
   vec_t        tv [N];

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(16)) dut16 (
      .clock(clk), .reset_n(rst_n), .in_valid(iv), .in_ready(ir), .in_op(op),
      .in_a(a), .in_b(b), .in_first(first), .out_valid(ov), .out_ready(ordy),
      .out_data(od), .out_any(oany), .out_zero(ozero), .out_parity(opar)
   );

   logic_unit_pipe #(.WIDTH(8)) dut8 (
      .clock(clk), .reset_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .in_op(op8),
      .in_a(a8), .in_b(b8), .in_first(first8), .out_valid(ov8), .out_ready(ordy8),
      .out_data(od8), .out_any(oany8), .out_zero(ozero8), .out_parity(opar8)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // PASSA with in_first=0 right after reset exposes the cleared accumulator.
      tv[0]  = '{3'd7, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
      tv[1]  = '{3'd0, 1'b1, 16'hF0F0, 16'hFF00, 16'hF000, 1'b1, 1'b0, 1'b0};
      tv[2]  = '{3'd1, 1'b1, 16'hF0F0, 16'hFF00, 16'hFFF0, 1'b1, 1'b0, 1'b0};
      tv[3]  = '{3'd2, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b1, 1'b0, 1'b0};
      tv[4]  = '{3'd3, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FFF, 1'b1, 1'b0, 1'b0};
      tv[5]  = '{3'd4, 1'b1, 16'hF0F0, 16'hFF00, 16'h000F, 1'b1, 1'b0, 1'b0};
      tv[6]  = '{3'd5, 1'b1, 16'hF0F0, 16'hFF00, 16'hF00F, 1'b1, 1'b0, 1'b0};
      tv[7]  = '{3'd6, 1'b1, 16'hF0F0, 16'hFF00, 16'h0F0F, 1'b1, 1'b0, 1'b0};
      tv[8]  = '{3'd7, 1'b1, 16'hF0F0, 16'hFF00, 16'hF0F0, 1'b1, 1'b0, 1'b0};
      tv[9]  = '{3'd1, 1'b1, 16'h0000, 16'h0001, 16'h0001, 1'b1, 1'b0, 1'b1};
      tv[10] = '{3'd1, 1'b0, 16'hFFFF, 16'h0100, 16'h0101, 1'b1, 1'b0, 1'b0};
      tv[11] = '{3'd1, 1'b0, 16'hFFFF, 16'h8000, 16'h8101, 1'b1, 1'b0, 1'b1};
      tv[12] = '{3'd2, 1'b1, 16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b1, 1'b0};

      rst_n = 1'b0; iv = 1'b1; op = 3'd7; a = 16'hFFFF; b = 16'hFFFF; first = 1'b1; ordy = 1'b1;
      rst8_n = 1'b0; iv8 = 1'b0; op8 = 3'd0; a8 = 8'h00; b8 = 8'h00; first8 = 1'b1; ordy8 = 1'b1;
      repeat (3) step();
      chk("rst_out_valid", ov, 1'b0);
      chk("rst_out_data", od, 16'h0000);
      chk("rst_out_zero", ozero, 1'b1);
      chk("rst_out_any", oany, 1'b0);
      chk("rst_out_parity", opar, 1'b0);
      rst_n = 1'b1;
      rst8_n = 1'b1;
      #1;
      chk("rst_in_ready", ir, 1'b1);

      for (int i = 0; i < N + 2; i++) begin
         if (i < N) begin
            iv = 1'b1; op = tv[i].op; first = tv[i].first; a = tv[i].a; b = tv[i].b;
            chk($sformatf("stream%0d_in_ready", i), ir, 1'b1);
         end else iv = 1'b0;
         if (i >= 2) begin
            chk($sformatf("vec%0d_valid", i - 2), ov, 1'b1);
            chk($sformatf("vec%0d_data", i - 2), od, tv[i-2].d);
            chk($sformatf("vec%0d_any", i - 2), oany, tv[i-2].any);
            chk($sformatf("vec%0d_zero", i - 2), ozero, tv[i-2].zero);
            chk($sformatf("vec%0d_parity", i - 2), opar, tv[i-2].par);
         end else chk($sformatf("lat%0d_valid", i), ov, 1'b0);
         step();
      end
      chk("stream_drained", ov, 1'b0);

      begin
         int accepted = 0;
         ordy = 1'b0; op = 3'd7; first = 1'b1; b = 16'h0000;
         for (int c = 0; c < 5; c++) begin
            iv = 1'b1;
            a = 16'h1111 * 16'(accepted + 1);
            if (ov) chk($sformatf("bp%0d_hold", c), od, 16'h1111);
            #1;
            if (ir) accepted++;
            step();
         end
         chk("bp_accepted", 64'(accepted), 64'd2);
         chk("bp_in_ready", ir, 1'b0);
         chk("bp_hold_valid", ov, 1'b1);
         chk("bp_hold_data", od, 16'h1111);
      end
      iv = 1'b0; ordy = 1'b1;
      chk("drain0_valid", ov, 1'b1);
      chk("drain0_data", od, 16'h1111);
      step();
      chk("drain1_valid", ov, 1'b1);
      chk("drain1_data", od, 16'h2222);
      step();
      chk("drain2_valid", ov, 1'b0);

      iv8 = 1'b1; op8 = 3'd1; first8 = 1'b1; a8 = 8'hAA; b8 = 8'h0F; ordy8 = 1'b0;
      step();
      step();
      iv8 = 1'b0;
      chk("w8_inflight_valid", ov8, 1'b1);
      chk("w8_inflight_in_ready", ir8, 1'b0);
      chk("w8_inflight_data", od8, 8'hAF);
      #2;
      rst8_n = 1'b0;
      #1;
      chk("w8_async_valid", ov8, 1'b0);
      chk("w8_async_data", od8, 8'h00);
      chk("w8_async_zero", ozero8, 1'b1);
      step();
      rst8_n = 1'b1;
      iv8 = 1'b1; op8 = 3'd0; first8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; ordy8 = 1'b1;
      step();
      iv8 = 1'b0;
      chk("w8_after_rst_valid0", ov8, 1'b0);
      step();
      chk("w8_acc_clear_valid", ov8, 1'b1);
      chk("w8_acc_clear_data", od8, 8'h00);
      chk("w8_acc_clear_zero", ozero8, 1'b1);
      chk("w8_acc_clear_any", oany8, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
